ysyx_23060240_idu_pipe: RTL

//  Registered RV32I/RV32E decode stage between IFU and EXU of the NPC, with valid/ready on both sides.

---
 rtl/ysyx_23060240_idu_pipe.sv | 338 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060240_idu_pipe.sv
// ---------------------------------------------------------------------------
// ysyx_23060240_idu_pipe
//   Registered RV32I / RV32E decode stage between the IFU and the EXU.
//   One instruction register with valid/ready handshakes on both sides.
//   ebreak and illegal encodings are passed downstream, and the stage then
//   stops until reset.
//
// Ports
//   clk, rst                    clock (rising edge), synchronous active-high reset
//   in_valid / in_ready         upstream handshake; transfer when both are high
//   in_inst, in_pc              instruction word and its address
//   flush                       drop the held instruction (redirect)
//   out_valid / out_ready       downstream handshake
//   out_pc, out_imm             registered pc, sign-extended immediate
//   out_rs1, out_rs2, out_rd    register index fields
//   out_alu_func                0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND 10 PASSB
//   out_alu_a_sel, out_alu_b_sel  operand A: rs1/pc, operand B: rs2/imm
//   out_w_en                    rd write enable (0 for x0)
//   out_cls                     0 ALU 1 LOAD 2 STORE 3 BRANCH 4 JUMP 5 SYS/NOP
//   halt, halt_code             stage stopped; 0 none, 1 ebreak, 2 illegal
// ---------------------------------------------------------------------------
module ysyx_23060240_idu_pipe #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int FUNC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_inst,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_imm,
   output logic [4:0]        out_rs1,
   output logic [4:0]        out_rs2,
   output logic [4:0]        out_rd,
   output logic [FUNC_W-1:0] out_alu_func,
   output logic              out_alu_a_sel,
   output logic              out_alu_b_sel,
   output logic              out_w_en,
   output logic [2:0]        out_cls,
   output logic              halt,
   output logic [1:0]        halt_code
);

   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OPIMM  = 7'h13;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_FENCE  = 7'h0F;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   localparam logic [FUNC_W-1:0] F_ADD   = FUNC_W'(0);
   localparam logic [FUNC_W-1:0] F_SUB   = FUNC_W'(1);
   localparam logic [FUNC_W-1:0] F_SLL   = FUNC_W'(2);
   localparam logic [FUNC_W-1:0] F_SLT   = FUNC_W'(3);
   localparam logic [FUNC_W-1:0] F_SLTU  = FUNC_W'(4);
   localparam logic [FUNC_W-1:0] F_XOR   = FUNC_W'(5);
   localparam logic [FUNC_W-1:0] F_SRL   = FUNC_W'(6);
   localparam logic [FUNC_W-1:0] F_SRA   = FUNC_W'(7);
   localparam logic [FUNC_W-1:0] F_OR    = FUNC_W'(8);
   localparam logic [FUNC_W-1:0] F_AND   = FUNC_W'(9);
   localparam logic [FUNC_W-1:0] F_PASSB = FUNC_W'(10);

   localparam logic [2:0] C_ALU    = 3'd0;
   localparam logic [2:0] C_LOAD   = 3'd1;
   localparam logic [2:0] C_STORE  = 3'd2;
   localparam logic [2:0] C_BRANCH = 3'd3;
   localparam logic [2:0] C_JUMP   = 3'd4;
   localparam logic [2:0] C_SYS    = 3'd5;

   localparam logic [1:0] HC_EBREAK = 2'd1;
   localparam logic [1:0] HC_ILL    = 2'd2;

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;

   localparam bit RVE = (NREG == 16);

   // ---- decode (combinational, from in_inst) ----
   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rs1_f, rs2_f, rd_f;

   assign opc   = in_inst[6:0];
   assign f3    = in_inst[14:12];
   assign f7    = in_inst[31:25];
   assign rs1_f = in_inst[19:15];
   assign rs2_f = in_inst[24:20];
   assign rd_f  = in_inst[11:7];

   logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
   assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign imm_u = {in_inst[31:12], 12'b0};
   assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

   // funct3 -> ALU op shared by OP and OP-IMM; funct7 refines SUB/SRA below
   logic [FUNC_W-1:0] arith_func;

   always_comb begin
      case (f3)
         3'd0:    arith_func = F_ADD;
         3'd1:    arith_func = F_SLL;
         3'd2:    arith_func = F_SLT;
         3'd3:    arith_func = F_SLTU;
         3'd4:    arith_func = F_XOR;
         3'd5:    arith_func = F_SRL;
         3'd6:    arith_func = F_OR;
         default: arith_func = F_AND;
      endcase
   end

   logic signed [31:0] dec_imm32;
   logic [FUNC_W-1:0]  dec_func;
   logic               dec_a, dec_b, dec_wr, dec_bad, dec_ebreak;
   logic [2:0]         dec_cls;
   logic               use_rs1, use_rs2, use_rd;

   always_comb begin
      dec_imm32  = '0;
      dec_func   = F_ADD;
      dec_a      = 1'b0;
      dec_b      = 1'b0;
      dec_wr     = 1'b0;
      dec_cls    = C_SYS;
      dec_bad    = 1'b0;
      dec_ebreak = 1'b0;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      use_rd     = 1'b0;
      case (opc)
         OPC_LUI: begin
            dec_imm32 = imm_u; dec_func = F_PASSB; dec_b = 1'b1;
            dec_wr = 1'b1; use_rd = 1'b1; dec_cls = C_ALU;
         end
         OPC_AUIPC: begin
            dec_imm32 = imm_u; dec_a = 1'b1; dec_b = 1'b1;
            dec_wr = 1'b1; use_rd = 1'b1; dec_cls = C_ALU;
         end
         OPC_JAL: begin
            dec_imm32 = imm_j; dec_a = 1'b1; dec_b = 1'b1;
            dec_wr = 1'b1; use_rd = 1'b1; dec_cls = C_JUMP;
         end
         OPC_JALR: begin
            dec_imm32 = imm_i; dec_a = 1'b1; dec_b = 1'b1;
            dec_wr = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1; dec_cls = C_JUMP;
            dec_bad = (f3 != 3'd0);
         end
         OPC_BRANCH: begin
            dec_imm32 = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; dec_cls = C_BRANCH;
            // EQ/NE compare by subtraction, signed and unsigned orderings by SLT/SLTU
            case (f3)
               3'd0, 3'd1: dec_func = F_SUB;
               3'd4, 3'd5: dec_func = F_SLT;
               3'd6, 3'd7: dec_func = F_SLTU;
               default:    dec_bad  = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            dec_imm32 = imm_i; dec_b = 1'b1; dec_wr = 1'b1;
            use_rs1 = 1'b1; use_rd = 1'b1; dec_cls = C_LOAD;
            dec_bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
         end
         OPC_STORE: begin
            dec_imm32 = imm_s; dec_b = 1'b1;
            use_rs1 = 1'b1; use_rs2 = 1'b1; dec_cls = C_STORE;
            dec_bad = (f3 > 3'd2);
         end
         OPC_OPIMM: begin
            dec_imm32 = imm_i; dec_b = 1'b1; dec_wr = 1'b1; dec_func = arith_func;
            use_rs1 = 1'b1; use_rd = 1'b1; dec_cls = C_ALU;
            // shift-immediates carry funct7 in imm[11:5]; imm[10] selects SRAI
            if (f3 == 3'd1 && f7 != 7'h00) dec_bad = 1'b1;
            if (f3 == 3'd5) begin
               if (f7 == 7'h20)      dec_func = F_SRA;
               else if (f7 != 7'h00) dec_bad  = 1'b1;
            end
         end
         OPC_OP: begin
            dec_func = arith_func; dec_wr = 1'b1;
            use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1; dec_cls = C_ALU;
            if (f7 == 7'h20) begin
               if (f3 == 3'd0)      dec_func = F_SUB;
               else if (f3 == 3'd5) dec_func = F_SRA;
               else                 dec_bad  = 1'b1;
            end else if (f7 != 7'h00) begin
               dec_bad = 1'b1;
            end
         end
         OPC_FENCE: begin
            dec_imm32 = imm_i;
            dec_bad   = (f3 != 3'd0);
         end
         OPC_SYSTEM: begin
            dec_imm32 = imm_i;
            if (in_inst == EBREAK) dec_ebreak = 1'b1;
            else                   dec_bad    = 1'b1;
         end
         default: dec_bad = 1'b1;
      endcase
      // RV32E: only the register fields the format actually uses are checked
      if (RVE && ((use_rs1 && rs1_f[4]) || (use_rs2 && rs2_f[4]) || (use_rd && rd_f[4])))
         dec_bad = 1'b1;
   end

   logic              trap;
   logic [1:0]        trap_code;
   logic              wen_d;
   logic [2:0]        cls_d;
   logic [XLEN-1:0]   imm_d;

   assign trap      = dec_bad || dec_ebreak;
   assign trap_code = dec_bad ? HC_ILL : HC_EBREAK;
   assign wen_d     = dec_wr && (rd_f != 5'd0) && !dec_bad;
   assign cls_d     = dec_bad ? C_SYS : dec_cls;
   assign imm_d     = XLEN'(dec_imm32);

   // ---- handshake and control FSM ----
   logic [1:0] state_q, state_d;
   logic       vld_q, vld_d;
   logic       halt_q, halt_d;
   logic [1:0] code_q, code_d;
   logic [1:0] pend_q, pend_d;   // halt code of the trapping instruction being drained
   logic       accept, drain;

   assign in_ready = (state_q == S_RUN) && (!vld_q || out_ready) && !flush;
   assign accept   = in_valid && in_ready;
   assign drain    = vld_q && out_ready;

   always_comb begin
      state_d = state_q;
      vld_d   = vld_q;
      halt_d  = halt_q;
      code_d  = code_q;
      pend_d  = pend_q;
      if (state_q != S_HALT) begin
         // flush wins over a trap drain: the instruction still leaves, but no halt
         if (flush) begin
            vld_d   = 1'b0;
            state_d = S_RUN;
            pend_d  = 2'd0;
         end else if (accept) begin
            vld_d = 1'b1;
            if (trap) begin
               state_d = S_DRAIN;
               pend_d  = trap_code;
            end
         end else if (drain) begin
            vld_d = 1'b0;
            if (state_q == S_DRAIN) begin
               state_d = S_HALT;
               halt_d  = 1'b1;
               code_d  = pend_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_RUN;
         vld_q   <= 1'b0;
         halt_q  <= 1'b0;
         code_q  <= 2'd0;
         pend_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         halt_q  <= halt_d;
         code_q  <= code_d;
         pend_q  <= pend_d;
      end
   end

   // ---- output register stage ----
   logic [XLEN-1:0]   pc_q, imm_q;
   logic [4:0]        rs1_q, rs2_q, rd_q;
   logic [FUNC_W-1:0] func_q;
   logic              asel_q, bsel_q, wen_q;
   logic [2:0]        cls_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= '0;
         imm_q  <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         rd_q   <= '0;
         func_q <= '0;
         asel_q <= 1'b0;
         bsel_q <= 1'b0;
         wen_q  <= 1'b0;
         cls_q  <= '0;
      end else if (accept) begin
         pc_q   <= in_pc;
         imm_q  <= imm_d;
         rs1_q  <= rs1_f;
         rs2_q  <= rs2_f;
         rd_q   <= rd_f;
         func_q <= dec_func;
         asel_q <= dec_a;
         bsel_q <= dec_b;
         wen_q  <= wen_d;
         cls_q  <= cls_d;
      end
   end

   assign out_valid     = vld_q;
   assign out_pc        = pc_q;
   assign out_imm       = imm_q;
   assign out_rs1       = rs1_q;
   assign out_rs2       = rs2_q;
   assign out_rd        = rd_q;
   assign out_alu_func  = func_q;
   assign out_alu_a_sel = asel_q;
   assign out_alu_b_sel = bsel_q;
   assign out_w_en      = wen_q;
   assign out_cls       = cls_q;
   assign halt          = halt_q;
   assign halt_code     = code_q;

endmodule
